// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the I/D cache memory-port arbiter.
package mem_arb_pkg;

    parameter int unsigned DEF_ADDR_W = 28;
    parameter int unsigned DEF_DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_arb_if.sv
// Cache-side and memory-side bus bundle for mem_arbiter.
// master = arbiter view, slave = caches + memory view.
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic              i_read;
    logic              i_write;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  i_read, i_write, i_addr, i_wdata,
        output i_rdata, i_ready,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        output i_read, i_write, i_addr, i_wdata,
        input  i_rdata, i_ready,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/mem_arb_stat.sv
// Saturating grant and wait-cycle counters for mem_arbiter (used with MEM_ARB_STAT_EN).
module mem_arb_stat (
    input  logic        clk,
    input  logic        rst,
    input  logic        gnt_i_i,
    input  logic        gnt_d_i,
    input  logic        wait_i,
    output logic [15:0] stat_i_grants_o,
    output logic [15:0] stat_d_grants_o,
    output logic [15:0] stat_wait_cycles_o
);

    logic [15:0] i_cnt_q, i_cnt_d;
    logic [15:0] d_cnt_q, d_cnt_d;
    logic [15:0] w_cnt_q, w_cnt_d;

    always_comb begin
        i_cnt_d = i_cnt_q;
        d_cnt_d = d_cnt_q;
        w_cnt_d = w_cnt_q;
        if (gnt_i_i && i_cnt_q != 16'hFFFF) i_cnt_d = i_cnt_q + 16'd1;
        if (gnt_d_i && d_cnt_q != 16'hFFFF) d_cnt_d = d_cnt_q + 16'd1;
        if (wait_i && w_cnt_q != 16'hFFFF)  w_cnt_d = w_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_cnt_q <= '0;
            d_cnt_q <= '0;
            w_cnt_q <= '0;
        end else begin
            i_cnt_q <= i_cnt_d;
            d_cnt_q <= d_cnt_d;
            w_cnt_q <= w_cnt_d;
        end
    end

    assign stat_i_grants_o    = i_cnt_q;
    assign stat_d_grants_o    = d_cnt_q;
    assign stat_wait_cycles_o = w_cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache and D-cache.
// Optional statistics counters are enabled with MEM_ARB_STAT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic       clk,
    input  logic       rst,
    mem_arb_if.master  bus
`ifdef MEM_ARB_STAT_EN
    ,
    output logic [15:0] stat_i_grants,
    output logic [15:0] stat_d_grants,
    output logic [15:0] stat_wait_cycles
`endif
);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              i_req, d_req;
    logic              gnt_i, gnt_d;

    always_comb begin
        i_req       = bus.i_read | bus.i_write;
        d_req       = bus.d_read | bus.d_write;
        gnt_i       = 1'b0;
        gnt_d       = 1'b0;
        state_d     = state_q;
        last_d      = last_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    gnt_d = (last_q == GNT_I);
                    gnt_i = (last_q == GNT_D);
                end else begin
                    gnt_i = i_req;
                    gnt_d = d_req;
                end
                // Write wins when a cache raises read and write together.
                if (gnt_i) begin
                    mem_addr_d  = bus.i_addr;
                    mem_wdata_d = bus.i_wdata;
                    mem_write_d = bus.i_write;
                    mem_read_d  = ~bus.i_write;
                    last_d      = GNT_I;
                    state_d     = I_BUSY;
                end else if (gnt_d) begin
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_write_d = bus.d_write;
                    mem_read_d  = ~bus.d_write;
                    last_d      = GNT_D;
                    state_d     = D_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (bus.mem_ready) begin
                    if (state_q == I_BUSY) begin
                        i_ready_d = 1'b1;
                        if (mem_read_q) i_rdata_d = bus.mem_rdata;
                    end else begin
                        d_ready_d = 1'b1;
                        if (mem_read_q) d_rdata_d = bus.mem_rdata;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_q      <= GNT_I;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_ready   = d_ready_q;

`ifdef MEM_ARB_STAT_EN
    logic i_wait, d_wait;

    // Outside IDLE the owner (busy or DONE target) is last_q.
    always_comb begin
        if (state_q == IDLE) begin
            i_wait = i_req & ~gnt_i;
            d_wait = d_req & ~gnt_d;
        end else begin
            i_wait = i_req & (last_q != GNT_I);
            d_wait = d_req & (last_q != GNT_D);
        end
    end

    mem_arb_stat u_stat (
        .clk               (clk),
        .rst               (rst),
        .gnt_i_i           (gnt_i),
        .gnt_d_i           (gnt_d),
        .wait_i            (i_wait | d_wait),
        .stat_i_grants_o   (stat_i_grants),
        .stat_d_grants_o   (stat_d_grants),
        .stat_wait_cycles_o(stat_wait_cycles)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a fixed-latency memory model.
module tb_mem_arbiter;

    logic clk;
    logic rst;

    mem_arb_if #(.ADDR_W(28), .DATA_W(128)) bus ();

`ifdef MEM_ARB_STAT_EN
    logic [15:0] stat_i_grants, stat_d_grants, stat_wait_cycles;
`endif

    mem_arbiter #(.ADDR_W(28), .DATA_W(128)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus)
`ifdef MEM_ARB_STAT_EN
        ,
        .stat_i_grants   (stat_i_grants),
        .stat_d_grants   (stat_d_grants),
        .stat_wait_cycles(stat_wait_cycles)
`endif
    );

    int            n_cmp = 0;
    int            n_err = 0;
    int            mem_lat = 4;
    logic [127:0]  mem_data = '0;
    bit            model_en = 1'b1;
    bit            manual_rdy = 1'b0;
    logic [27:0]   glog[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: ready pulse so that the strobe is high for mem_lat cycles.
    initial begin : mem_model
        int cnt;
        cnt = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                cnt = 0;
                bus.mem_ready = 1'b0;
            end else if (!model_en) begin
                cnt = 0;
                bus.mem_ready = manual_rdy;
            end else if (bus.mem_read || bus.mem_write) begin
                cnt++;
                bus.mem_ready = (cnt == mem_lat);
                if (cnt == mem_lat) cnt = 0;
            end else begin
                cnt = 0;
                bus.mem_ready = 1'b0;
            end
            bus.mem_rdata = bus.mem_ready ? mem_data : '0;
        end
    end

    initial begin : grant_mon
        bit prev;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if ((bus.mem_read || bus.mem_write) && !prev) glog.push_back(bus.mem_addr);
            prev = bus.mem_read || bus.mem_write;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] glog_at(input int idx);
        if (idx < glog.size()) return glog[idx];
        return '1;
    endfunction

    task automatic clear_reqs();
        bus.i_read  = 1'b0;
        bus.i_write = 1'b0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        clear_reqs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ready(input bit want_d, input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #2;
            if (want_d ? bus.d_ready : bus.i_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq(tag, 128'(seen), 128'd1);
    endtask

    task automatic wait_any(input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #2;
            if (bus.i_ready || bus.d_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq(tag, 128'(seen), 128'd1);
    endtask

    initial begin : main
        int  rd_cyc;
        int  gap;
        int  base;
        bit  seen;
        bit  d_seen;
        logic [27:0] addr_obs;

        rst = 1'b0;
        clear_reqs();
        bus.i_addr  = '0;
        bus.i_wdata = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_mem_read", 128'(bus.mem_read), 128'd0);
        check_eq("rst_mem_write", 128'(bus.mem_write), 128'd0);
        check_eq("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
        check_eq("rst_mem_wdata", bus.mem_wdata, 128'd0);
        check_eq("rst_readys", {126'd0, bus.i_ready, bus.d_ready}, 128'd0);
        check_eq("rst_i_rdata", bus.i_rdata, 128'd0);
        check_eq("rst_d_rdata", bus.d_rdata, 128'd0);
`ifdef MEM_ARB_STAT_EN
        check_eq("rst_stats", {80'd0, stat_i_grants, stat_d_grants, stat_wait_cycles}, 128'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;

        // 1: lone I read, latency 4
        mem_lat  = 4;
        mem_data = {16{8'hA5}};
        bus.i_addr = 28'h10;
        bus.i_read = 1'b1;
        rd_cyc = 0; seen = 1'b0; d_seen = 1'b0; addr_obs = '1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #2;
            if (bus.mem_read) begin
                rd_cyc++;
                addr_obs = bus.mem_addr;
            end
            if (bus.d_ready) d_seen = 1'b1;
            if (bus.i_ready) begin
                seen = 1'b1;
                break;
            end
        end
        bus.i_read = 1'b0;
        check_eq("t1_rd_cycles", 128'(rd_cyc), 128'd4);
        check_eq("t1_mem_addr", 128'(addr_obs), 128'h10);
        check_eq("t1_i_ready_seen", 128'(seen), 128'd1);
        check_eq("t1_i_rdata", bus.i_rdata, {16{8'hA5}});
        check_eq("t1_d_ready_quiet", 128'(d_seen), 128'd0);
        check_eq("t1_d_rdata", bus.d_rdata, 128'd0);
        @(posedge clk);
        #2;
        check_eq("t1_i_ready_pulse", 128'(bus.i_ready), 128'd0);

        // 2: simultaneous requests after reset go D first, then I
        do_reset();
        mem_data = 128'h0D0D;
        bus.i_addr = 28'h100;
        bus.d_addr = 28'h200;
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        base = glog.size();
        wait_ready(1'b1, "t2_d_ready");
        bus.d_read = 1'b0;
        check_eq("t2_first_grant", 128'(glog_at(base)), 128'h200);
        gap = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #2;
            gap++;
            if (bus.mem_read) break;
        end
        check_eq("t2_i_gap", 128'(gap), 128'd2);
        check_eq("t2_i_addr", 128'(bus.mem_addr), 128'h100);
        wait_ready(1'b0, "t2_i_ready");
        bus.i_read = 1'b0;
        check_eq("t2_i_rdata", bus.i_rdata, 128'h0D0D);

        // 3: continuous contention alternates D,I,...
        do_reset();
        mem_lat  = 2;
        mem_data = 128'hC0FFEE;
        bus.i_addr = 28'h310;
        bus.d_addr = 28'h320;
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        base = glog.size();
        for (int k = 0; k < 6; k++) wait_any($sformatf("t3_ready%0d", k));
        clear_reqs();
        repeat (3) @(posedge clk);
        #2;
        check_eq("t3_n_grants", 128'(glog.size() - base), 128'd6);
        for (int k = 0; k < 6; k++)
            check_eq($sformatf("t3_grant%0d", k), 128'(glog_at(base + k)),
                     (k % 2 == 0) ? 128'h320 : 128'h310);
`ifdef MEM_ARB_STAT_EN
        check_eq("t3_stat_i", 128'(stat_i_grants), 128'd3);
        check_eq("t3_stat_d", 128'(stat_d_grants), 128'd3);
`endif

        // 4: read+write together: write wins, rdata untouched
        mem_data = 128'hBAD;
        bus.d_addr  = 28'h20;
        bus.d_wdata = 128'h1234;
        bus.d_read  = 1'b1;
        bus.d_write = 1'b1;
        @(posedge clk);
        #2;
        check_eq("t4_mem_write", 128'(bus.mem_write), 128'd1);
        check_eq("t4_mem_read", 128'(bus.mem_read), 128'd0);
        check_eq("t4_mem_wdata", bus.mem_wdata, 128'h1234);
        check_eq("t4_mem_addr", 128'(bus.mem_addr), 128'h20);
        wait_ready(1'b1, "t4_d_ready");
        clear_reqs();
        check_eq("t4_d_rdata_kept", bus.d_rdata, 128'hC0FFEE);

        // 5: request held into DONE is not granted; held into IDLE it is
        mem_data = 128'h55;
        bus.d_addr = 28'h40;
        bus.d_read = 1'b1;
        wait_ready(1'b1, "t5a_d_ready");
        base = glog.size();
        @(posedge clk);
        #2;
        check_eq("t5a_done_no_grant", 128'(bus.mem_read), 128'd0);
        bus.d_read = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_eq("t5a_no_new_grant", 128'(glog.size() - base), 128'd0);
        bus.d_read = 1'b1;
        wait_ready(1'b1, "t5b_d_ready");
        @(posedge clk);
        #2;
        check_eq("t5b_done_no_grant", 128'(bus.mem_read), 128'd0);
        @(posedge clk);
        #2;
        check_eq("t5b_idle_grant", 128'(bus.mem_read), 128'd1);
        bus.d_read = 1'b0;
        wait_ready(1'b1, "t5b_second_ready");

        // 6: reset in D_BUSY abandons the access
        mem_lat  = 4;
        mem_data = 128'h77;
        bus.d_addr = 28'h30;
        bus.d_read = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_eq("t6_busy", 128'(bus.mem_read), 128'd1);
        rst = 1'b0;
        clear_reqs();
        #1;
        check_eq("t6_rst_strobes", {126'd0, bus.mem_read, bus.mem_write}, 128'd0);
        check_eq("t6_rst_addr", 128'(bus.mem_addr), 128'd0);
        check_eq("t6_rst_rdata", bus.d_rdata | bus.i_rdata, 128'd0);
        check_eq("t6_rst_ready", {126'd0, bus.i_ready, bus.d_ready}, 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_en = 1'b0;
        @(posedge clk);
        #2;
        manual_rdy = 1'b1;
        d_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #2;
            manual_rdy = 1'b0;
            if (bus.d_ready || bus.i_ready) d_seen = 1'b1;
        end
        check_eq("t6_stray_ready", 128'(d_seen), 128'd0);
        model_en = 1'b1;
        bus.i_addr = 28'h610;
        bus.d_addr = 28'h620;
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        @(posedge clk);
        #2;
        check_eq("t6_regrant_addr", 128'(bus.mem_addr), 128'h620);
        wait_ready(1'b1, "t6_d_ready");
        bus.d_read = 1'b0;
        wait_ready(1'b0, "t6_i_ready");
        bus.i_read = 1'b0;
        check_eq("t6_i_rdata", bus.i_rdata, 128'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
